wb_intercon: RTL and testbench

Single-master Wishbone interconnect placed directly downstream of the OISC bus master and upstream of all peripheral slaves (SPI RAM, SPI ROM, UART, GPIO, BRAM, SPI). It decodes the one-hot address map, registers the request toward the selected slave, and returns the response to the master. It converts unmapped accesses and stalled slaves into a one-cycle bus error, and records the first fault for software.

---
 rtl/wb_intercon_pkg.sv | 22 ++
 rtl/wb_addr_decode.sv | 24 ++
 rtl/wb_intercon.sv | 182 ++++++++++++++++++
 tb/tb_wb_intercon.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_intercon_pkg.sv
// Shared constants for the single-master Wishbone interconnect: slave indices,
// fault codes and FSM state encoding.
package wb_intercon_pkg;

   localparam int SLV_SPI_RAM = 0;
   localparam int SLV_SPI_ROM = 1;
   localparam int SLV_UART    = 2;
   localparam int SLV_GPIO    = 3;
   localparam int SLV_BRAM    = 4;
   localparam int SLV_SPI     = 5;

   localparam logic [1:0] FAULT_UNMAPPED = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_RESP = 2'd2;
   localparam state_t ST_ERR  = 2'd3;

endpackage

// File: rtl/wb_addr_decode.sv
// One-hot address decoder: the highest set bit of the slave tag field selects the
// slave, so bit 31 (slave 0) has top priority.
module wb_addr_decode #(
   parameter int NSLV  = 6,
   parameter int IDX_W = 3
) (
   input  logic [NSLV-1:0]  tag_i,
   output logic             hit_o,
   output logic [IDX_W-1:0] idx_o
);

   // tag_i[NSLV-1] is address bit 31; walking k downward lets the lowest index win
   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      for (int k = NSLV - 1; k >= 0; k--) begin
         if (tag_i[NSLV-1-k]) begin
            hit_o = 1'b1;
            idx_o = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/wb_intercon.sv
// Single-master Wishbone interconnect: registered request toward the decoded slave,
// one-cycle error for unmapped or timed-out accesses, sticky first-fault record.
module wb_intercon
   import wb_intercon_pkg::*;
#(
   parameter int NSLV    = 6,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_cyc_i,
   input  logic                 m_stb_i,
   input  logic                 m_we_i,
   input  logic [3:0]           m_sel_i,
   input  logic [31:0]          m_adr_i,
   input  logic [31:0]          m_dat_i,
   output logic                 m_ack_o,
   output logic                 m_err_o,
   output logic [31:0]          m_dat_o,
   output logic [NSLV-1:0]      s_cyc_o,
   output logic                 s_stb_o,
   output logic                 s_we_o,
   output logic [3:0]           s_sel_o,
   output logic [31:0]          s_adr_o,
   output logic [31:0]          s_dat_o,
   input  logic [NSLV-1:0]      s_ack_i,
   input  logic [NSLV*32-1:0]   s_dat_i,
   output logic                 fault_valid_o,
   output logic [1:0]           fault_code_o,
   output logic [31:0]          fault_adr_o,
   input  logic                 fault_clr_i
);

   localparam int         IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      wdat_q, wdat_d;
   logic [31:0]      rdat_q, rdat_d;
   logic [3:0]       sel_q, sel_d;
   logic             we_q, we_d;
   logic [7:0]       timer_q, timer_d;
   logic             fv_q, fv_d;
   logic [1:0]       fcode_q, fcode_d;
   logic [31:0]      fadr_q, fadr_d;

   logic             dec_hit;
   logic [IDX_W-1:0] dec_idx;
   logic             ack_sel;
   logic [31:0]      slv_rdat;
   logic             flt_ev;
   logic [1:0]       flt_code;
   logic [31:0]      flt_adr;

   wb_addr_decode #(
      .NSLV  (NSLV),
      .IDX_W (IDX_W)
   ) u_dec (
      .tag_i (m_adr_i[31 -: NSLV]),
      .hit_o (dec_hit),
      .idx_o (dec_idx)
   );

   // Only the latched slave's ack and data are visible; stray acks are dropped here
   always_comb begin
      ack_sel  = 1'b0;
      slv_rdat = '0;
      s_cyc_o  = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (idx_q == IDX_W'(k)) begin
            ack_sel    = s_ack_i[k];
            slv_rdat   = s_dat_i[32*k +: 32];
            s_cyc_o[k] = (state_q == ST_BUSY);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      adr_d    = adr_q;
      wdat_d   = wdat_q;
      sel_d    = sel_q;
      we_d     = we_q;
      timer_d  = timer_q;
      rdat_d   = rdat_q;
      flt_ev   = 1'b0;
      flt_code = FAULT_UNMAPPED;
      flt_adr  = m_adr_i;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               if (dec_hit) begin
                  idx_d   = dec_idx;
                  adr_d   = m_adr_i;
                  wdat_d  = m_dat_i;
                  sel_d   = m_sel_i;
                  we_d    = m_we_i;
                  timer_d = '0;
                  state_d = ST_BUSY;
               end else begin
                  rdat_d  = '0;
                  flt_ev  = 1'b1;
                  state_d = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            if (!m_cyc_i) begin
               state_d = ST_IDLE;
            end else if (ack_sel) begin
               rdat_d  = slv_rdat;
               state_d = ST_RESP;
            end else if (timer_q == TMO_LAST) begin
               rdat_d   = '0;
               flt_ev   = 1'b1;
               flt_code = FAULT_TIMEOUT;
               flt_adr  = adr_q;
               state_d  = ST_ERR;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A clear in the same cycle as a new fault still lets the new fault in
   always_comb begin
      fv_d    = fv_q & ~fault_clr_i;
      fcode_d = fcode_q;
      fadr_d  = fadr_q;
      if (flt_ev && !fv_d) begin
         fv_d    = 1'b1;
         fcode_d = flt_code;
         fadr_d  = flt_adr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         timer_q <= '0;
         fv_q    <= 1'b0;
         fcode_q <= '0;
         fadr_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         timer_q <= timer_d;
         fv_q    <= fv_d;
         fcode_q <= fcode_d;
         fadr_q  <= fadr_d;
      end
   end

   assign m_ack_o       = (state_q == ST_RESP);
   assign m_err_o       = (state_q == ST_ERR);
   assign m_dat_o       = rdat_q;
   assign s_stb_o       = (state_q == ST_BUSY);
   assign s_we_o        = we_q;
   assign s_sel_o       = sel_q;
   assign s_adr_o       = adr_q;
   assign s_dat_o       = wdat_q;
   assign fault_valid_o = fv_q;
   assign fault_code_o  = fcode_q;
   assign fault_adr_o   = fadr_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Self-checking bench for wb_intercon: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_wb_intercon;
   import wb_intercon_pkg::*;

   localparam int NSLV    = 6;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                rst;
   logic                m_cyc_i, m_stb_i, m_we_i;
   logic [3:0]          m_sel_i;
   logic [31:0]         m_adr_i, m_dat_i;
   logic                m_ack_o, m_err_o;
   logic [31:0]         m_dat_o;
   logic [NSLV-1:0]     s_cyc_o;
   logic                s_stb_o, s_we_o;
   logic [3:0]          s_sel_o;
   logic [31:0]         s_adr_o, s_dat_o;
   logic [NSLV-1:0]     s_ack_i;
   logic [NSLV*32-1:0]  s_dat_i;
   logic                fault_valid_o;
   logic [1:0]          fault_code_o;
   logic [31:0]         fault_adr_o;
   logic                fault_clr_i;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] slv_dat [NSLV];
   logic        m_fv   = 1'b0;
   logic [1:0]  m_code = 2'b00;
   logic [31:0] m_fadr = 32'h0;

   always #5 clk = ~clk;

   wb_intercon #(.NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .fault_valid_o(fault_valid_o), .fault_code_o(fault_code_o),
      .fault_adr_o(fault_adr_o), .fault_clr_i(fault_clr_i)
   );

   // Slave selected by an address: the highest set bit among 31..32-NSLV, or -1
   function automatic int model_slave(input logic [31:0] a);
      for (int k = 0; k < NSLV; k++)
         if (a[31-k]) return k;
      return -1;
   endfunction

   // Sticky fault register: a clear drops the flag, then a fault lands if the flag is free
   task automatic model_fault(input logic clr, input logic ev, input logic [1:0] code,
                              input logic [31:0] a);
      if (clr) m_fv = 1'b0;
      if (ev && !m_fv) begin
         m_fv   = 1'b1;
         m_code = code;
         m_fadr = a;
      end
   endtask

   // Drives one master transaction starting in the current cycle (cycle 0) and acts
   // as the slave: the addressed slave acks in BUSY cycle ack_dly (0 = never).
   task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] sel, input int ack_dly, input logic [31:0] kdat,
                          input logic [NSLV-1:0] stray, input logic clr,
                          output int kind, output int rcyc, output logic [31:0] rdat,
                          output logic [NSLV-1:0] cyc1, output logic [31:0] sadr1,
                          output logic [31:0] sdat1, output logic [3:0] sel1,
                          output logic we1, output logic stb1, output logic pulse_ok);
      int ek;
      ek = model_slave(adr);
      for (int k = 0; k < NSLV; k++) begin
         slv_dat[k] = (k == ek) ? kdat : $urandom;
         s_dat_i[32*k +: 32] = slv_dat[k];
      end
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
      m_adr_i = adr; m_dat_i = wdat; m_sel_i = sel;
      fault_clr_i = clr;
      s_ack_i = stray;
      kind = 0; rcyc = -1; rdat = '0;
      cyc1 = '0; sadr1 = '0; sdat1 = '0; sel1 = '0; we1 = 1'b0; stb1 = 1'b0;
      for (int c = 1; c <= TIMEOUT + 8 && kind == 0; c++) begin
         @(posedge clk); #1;
         fault_clr_i = 1'b0;
         if (c == 1) begin
            cyc1 = s_cyc_o; sadr1 = s_adr_o; sdat1 = s_dat_o;
            sel1 = s_sel_o; we1 = s_we_o; stb1 = s_stb_o;
         end
         if (m_ack_o || m_err_o) begin
            kind = m_ack_o ? (m_err_o ? 3 : 1) : 2;
            rcyc = c;
            rdat = m_dat_o;
            m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0;
         end else begin
            s_ack_i = stray | ((ack_dly == c && ek >= 0) ? (NSLV'(1) << ek) : NSLV'(0));
         end
      end
      @(posedge clk); #1;
      pulse_ok = !m_ack_o && !m_err_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
      s_ack_i = '0; s_dat_i = '0; fault_clr_i = 0;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if ({m_ack_o, m_err_o, s_stb_o, s_we_o, s_cyc_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ack=%b err=%b stb=%b we=%b cyc=%b, want all 0",
                  m_ack_o, m_err_o, s_stb_o, s_we_o, s_cyc_o);
      end
      n_assert++;
      if ({m_dat_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got mdat=%h adr=%h sdat=%h sel=%h, want 0",
                  m_dat_o, s_adr_o, s_dat_o, s_sel_o);
      end
      n_assert++;
      if ({fault_valid_o, fault_code_o, fault_adr_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_fault: got v=%b code=%b adr=%h, want 0",
                  fault_valid_o, fault_code_o, fault_adr_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_gpio_read();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      run_txn(32'h1000_0004, 1'b0, 32'h0, 4'hF, 1, 32'h0000_000A, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      n_assert++;
      if (c1 !== 6'b001000 || stb1 !== 1'b1) begin
         n_fail++;
         $display("FAIL gpio_cyc: got cyc=%b stb=%b, want 001000 1", c1, stb1);
      end
      n_assert++;
      if (kind !== 1 || rcyc !== 2 || rdat !== 32'h0000_000A) begin
         n_fail++;
         $display("FAIL gpio_resp: got kind=%0d cyc=%0d dat=%h, want ack at 2 dat 0000000a",
                  kind, rcyc, rdat);
      end
      n_assert++;
      if (pok !== 1'b1 || sa !== 32'h1000_0004 || we1 !== 1'b0) begin
         n_fail++;
         $display("FAIL gpio_misc: got single=%b adr=%h we=%b, want 1 10000004 0", pok, sa, we1);
      end
   endtask

   task automatic test_priority_decode();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      run_txn(32'hC000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0110, 2, 32'h1234_5678, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      n_assert++;
      if (c1 !== 6'b000001 || sa !== 32'hC000_0010) begin
         n_fail++;
         $display("FAIL prio_decode: got cyc=%b adr=%h, want 000001 c0000010", c1, sa);
      end
      n_assert++;
      if (sd !== 32'hDEAD_BEEF || we1 !== 1'b1 || sl !== 4'b0110) begin
         n_fail++;
         $display("FAIL prio_fields: got dat=%h we=%b sel=%b, want deadbeef 1 0110", sd, we1, sl);
      end
      n_assert++;
      if (kind !== 1 || rcyc !== 3 || rdat !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL prio_resp: got kind=%0d cyc=%0d dat=%h, want ack at 3 dat 12345678",
                  kind, rcyc, rdat);
      end
   endtask

   task automatic test_unmapped();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      run_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 1, 32'h0, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      model_fault(1'b0, 1'b1, FAULT_UNMAPPED, 32'h0000_1000);
      n_assert++;
      if (kind !== 2 || rcyc !== 1 || c1 !== '0 || rdat !== 32'h0 || pok !== 1'b1) begin
         n_fail++;
         $display("FAIL unmapped_err: got kind=%0d cyc=%0d scyc=%b dat=%h single=%b, want err at 1",
                  kind, rcyc, c1, rdat, pok);
      end
      n_assert++;
      if (fault_valid_o !== 1'b1 || fault_code_o !== 2'b01 || fault_adr_o !== 32'h0000_1000) begin
         n_fail++;
         $display("FAIL unmapped_fault: got v=%b code=%b adr=%h, want 1 01 00001000",
                  fault_valid_o, fault_code_o, fault_adr_o);
      end
   endtask

   task automatic test_timeout_faults();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      // clear travels with the request so the later timeout fault is free to land
      run_txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0, '0, 1'b1,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      model_fault(1'b1, 1'b1, FAULT_TIMEOUT, 32'h2000_0000);
      n_assert++;
      if (kind !== 2 || rcyc !== TIMEOUT + 1 || c1 !== 6'b000100) begin
         n_fail++;
         $display("FAIL timeout_err: got kind=%0d cyc=%0d scyc=%b, want err at %0d",
                  kind, rcyc, c1, TIMEOUT + 1);
      end
      n_assert++;
      if (fault_valid_o !== 1'b1 || fault_code_o !== 2'b10 || fault_adr_o !== 32'h2000_0000) begin
         n_fail++;
         $display("FAIL timeout_fault: got v=%b code=%b adr=%h, want 1 10 20000000",
                  fault_valid_o, fault_code_o, fault_adr_o);
      end
      run_txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 1, 32'h0, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      model_fault(1'b0, 1'b1, FAULT_UNMAPPED, 32'h0000_0040);
      n_assert++;
      if (kind !== 2 || fault_code_o !== 2'b10 || fault_adr_o !== 32'h2000_0000) begin
         n_fail++;
         $display("FAIL fault_sticky: got kind=%0d code=%b adr=%h, want err 10 20000000",
                  kind, fault_code_o, fault_adr_o);
      end
      run_txn(32'h0100_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0, '0, 1'b1,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      model_fault(1'b1, 1'b1, FAULT_UNMAPPED, 32'h0100_0000);
      n_assert++;
      if (fault_valid_o !== 1'b1 || fault_code_o !== 2'b01 || fault_adr_o !== 32'h0100_0000) begin
         n_fail++;
         $display("FAIL clr_vs_fault: got v=%b code=%b adr=%h, want 1 01 01000000",
                  fault_valid_o, fault_code_o, fault_adr_o);
      end
      fault_clr_i = 1'b1;
      @(posedge clk); #1;
      fault_clr_i = 1'b0;
      model_fault(1'b1, 1'b0, 2'b00, 32'h0);
      n_assert++;
      if (fault_valid_o !== 1'b0 || fault_code_o !== 2'b01 || fault_adr_o !== 32'h0100_0000) begin
         n_fail++;
         $display("FAIL clr_only: got v=%b code=%b adr=%h, want 0 01 01000000",
                  fault_valid_o, fault_code_o, fault_adr_o);
      end
   endtask

   task automatic test_late_ack_stray();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      run_txn(32'h0800_0000, 1'b0, 32'h0, 4'hF, TIMEOUT, 32'hB0B0_0064, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      n_assert++;
      if (kind !== 1 || rcyc !== TIMEOUT + 1 || rdat !== 32'hB0B0_0064 || fault_valid_o !== m_fv) begin
         n_fail++;
         $display("FAIL late_ack: got kind=%0d cyc=%0d dat=%h fv=%b, want ack at %0d dat b0b00064",
                  kind, rcyc, rdat, fault_valid_o, TIMEOUT + 1);
      end
      run_txn(32'h0800_0000, 1'b0, 32'h0, 4'hF, TIMEOUT + 1, 32'h0, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      model_fault(1'b0, 1'b1, FAULT_TIMEOUT, 32'h0800_0000);
      n_assert++;
      if (kind !== 2 || rcyc !== TIMEOUT + 1 || fault_code_o !== m_code || fault_adr_o !== m_fadr) begin
         n_fail++;
         $display("FAIL ack_too_late: got kind=%0d cyc=%0d code=%b adr=%h, want err at %0d code %b adr %h",
                  kind, rcyc, fault_code_o, fault_adr_o, TIMEOUT + 1, m_code, m_fadr);
      end
      run_txn(32'h0800_0000, 1'b0, 32'h0, 4'hF, 3, 32'hCAFE_0004, 6'b000100, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      n_assert++;
      if (kind !== 1 || rcyc !== 4 || rdat !== 32'hCAFE_0004) begin
         n_fail++;
         $display("FAIL stray_ack: got kind=%0d cyc=%0d dat=%h, want ack at 4 dat cafe0004",
                  kind, rcyc, rdat);
      end
   endtask

   task automatic test_abort();
      logic bad;
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 4'hF;
      m_adr_i = 32'h1000_0000; m_dat_i = '0; s_ack_i = '0;
      repeat (3) begin @(posedge clk); #1; end
      n_assert++;
      if (s_cyc_o !== 6'b001000 || s_stb_o !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy: got cyc=%b stb=%b, want 001000 1", s_cyc_o, s_stb_o);
      end
      // the slave acks in the very cycle the master gives up: the abort must win
      m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 6'b001000;
      @(posedge clk); #1;
      s_ack_i = '0;
      n_assert++;
      if (s_cyc_o !== '0 || s_stb_o !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: got cyc=%b stb=%b, want 0 0", s_cyc_o, s_stb_o);
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (m_ack_o || m_err_o) bad = 1'b1;
         @(posedge clk); #1;
      end
      n_assert++;
      if (bad !== 1'b0 || fault_valid_o !== m_fv) begin
         n_fail++;
         $display("FAIL abort_quiet: got resp_seen=%b fv=%b, want 0 %b", bad, fault_valid_o, m_fv);
      end
   endtask

   task automatic test_random();
      int kind, rcyc, ek, dly, ekind, ecyc, mode;
      logic [31:0] rdat, sa, sd, adr, wd, kd, edat; logic [NSLV-1:0] c1, ecyc1;
      logic [3:0] sl, sel; logic we1, stb1, pok, we, clr;
      for (int t = 0; t < 24; t++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0:       adr = (32'h8000_0000 >> $urandom_range(0, NSLV - 1)) | ($urandom & 32'h00FF_FFFF);
            1:       adr = $urandom & 32'h03FF_FFFF;
            default: adr = $urandom;
         endcase
         dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
         we  = 1'($urandom);
         wd  = $urandom;
         kd  = $urandom;
         sel = 4'($urandom);
         clr = ($urandom_range(0, 3) == 0);
         run_txn(adr, we, wd, sel, dly, kd, '0, clr,
                 kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
         ek = model_slave(adr);
         if (ek < 0) begin
            ekind = 2; ecyc = 1; edat = '0; ecyc1 = '0;
            model_fault(clr, 1'b1, FAULT_UNMAPPED, adr);
         end else if (dly >= 1 && dly <= TIMEOUT) begin
            ekind = 1; ecyc = dly + 1; edat = kd; ecyc1 = NSLV'(1) << ek;
            model_fault(clr, 1'b0, 2'b00, adr);
         end else begin
            ekind = 2; ecyc = TIMEOUT + 1; edat = '0; ecyc1 = NSLV'(1) << ek;
            model_fault(clr, 1'b1, FAULT_TIMEOUT, adr);
         end
         n_assert++;
         if (kind !== ekind || rcyc !== ecyc || rdat !== edat || c1 !== ecyc1 || pok !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_resp[%0d] adr=%h: got kind=%0d cyc=%0d dat=%h scyc=%b single=%b, want kind=%0d cyc=%0d dat=%h scyc=%b",
                     t, adr, kind, rcyc, rdat, c1, pok, ekind, ecyc, edat, ecyc1);
         end
         if (ek >= 0) begin
            n_assert++;
            if (sa !== adr || sd !== wd || sl !== sel || we1 !== we || stb1 !== 1'b1) begin
               n_fail++;
               $display("FAIL rand_fields[%0d]: got adr=%h dat=%h sel=%h we=%b stb=%b, want %h %h %h %b 1",
                        t, sa, sd, sl, we1, stb1, adr, wd, sel, we);
            end
         end
         n_assert++;
         if (fault_valid_o !== m_fv || fault_code_o !== m_code || fault_adr_o !== m_fadr) begin
            n_fail++;
            $display("FAIL rand_fault[%0d]: got v=%b code=%b adr=%h, want %b %b %h",
                     t, fault_valid_o, fault_code_o, fault_adr_o, m_fv, m_code, m_fadr);
         end
      end
   endtask

   task automatic test_reset_mid();
      int kind, rcyc; logic [31:0] rdat, sa, sd; logic [NSLV-1:0] c1; logic [3:0] sl;
      logic we1, stb1, pok;
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_sel_i = 4'hF;
      m_adr_i = 32'h2000_0000; m_dat_i = 32'h5555_AAAA; s_ack_i = '0;
      repeat (2) begin @(posedge clk); #1; end
      n_assert++;
      if (s_cyc_o !== 6'b000100) begin
         n_fail++;
         $display("FAIL rstmid_busy: got cyc=%b, want 000100", s_cyc_o);
      end
      rst = 1'b1;
      #1;
      n_assert++;
      if ({m_ack_o, m_err_o, s_stb_o, s_we_o, s_cyc_o, fault_valid_o, fault_code_o} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_ctrl: got ack=%b err=%b stb=%b we=%b cyc=%b fv=%b code=%b, want 0",
                  m_ack_o, m_err_o, s_stb_o, s_we_o, s_cyc_o, fault_valid_o, fault_code_o);
      end
      n_assert++;
      if ({m_dat_o, s_adr_o, s_dat_o, s_sel_o, fault_adr_o} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_data: got mdat=%h adr=%h sdat=%h sel=%h fadr=%h, want 0",
                  m_dat_o, s_adr_o, s_dat_o, s_sel_o, fault_adr_o);
      end
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_fv = 1'b0; m_code = 2'b00; m_fadr = 32'h0;
      run_txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0BAD_F00D, '0, 1'b0,
              kind, rcyc, rdat, c1, sa, sd, sl, we1, stb1, pok);
      n_assert++;
      if (kind !== 1 || rcyc !== 2 || rdat !== 32'h0BAD_F00D || fault_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_recover: got kind=%0d cyc=%0d dat=%h fv=%b, want ack at 2 dat 0badf00d fv 0",
                  kind, rcyc, rdat, fault_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_gpio_read();
      test_priority_decode();
      test_unmapped();
      test_timeout_faults();
      test_late_ack_stray();
      test_abort();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
